// File: rtl/ysyx_22040759_id_ex_reg_if.sv
// ID/EX pipeline register bus: decoded ID fields, pipeline control,
// writeback snoop inputs and the registered EX-side view.
interface ysyx_22040759_id_ex_reg_if #(
    parameter int XLEN    = 64,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 32
);
    // ID stage
    logic               id_valid;
    logic [XLEN-1:0]    id_pc;
    logic [RA_W-1:0]    id_rs1;
    logic [RA_W-1:0]    id_rs2;
    logic               id_rs1_ren;
    logic               id_rs2_ren;
    logic [RA_W-1:0]    id_rd;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic               id_regwrite;
    logic               id_memread;
    logic               id_memwrite;
    logic [ALUOP_W-1:0] id_alu_op;
    // pipeline control
    logic               ex_stall;
    logic               flush;
    // writeback snoop
    logic               wb_regwrite;
    logic [RA_W-1:0]    wb_rd;
    logic [XLEN-1:0]    wb_data;
    // EX side
    logic               load_use_stall;
    logic               ex_valid;
    logic [XLEN-1:0]    ex_pc;
    logic [RA_W-1:0]    ID_EX_RegisterRs1;
    logic [RA_W-1:0]    ID_EX_RegisterRs2;
    logic [RA_W-1:0]    ex_rd;
    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [XLEN-1:0]    ex_imm;
    logic               ex_regwrite;
    logic               ex_memread;
    logic               ex_memwrite;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rs1_ren, id_rs2_ren, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_regwrite, id_memread,
               id_memwrite, id_alu_op, ex_stall, flush, wb_regwrite, wb_rd, wb_data,
        input  load_use_stall, ex_valid, ex_pc, ID_EX_RegisterRs1, ID_EX_RegisterRs2,
               ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_regwrite, ex_memread,
               ex_memwrite, ex_alu_op, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_ren, id_rs2_ren, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_regwrite, id_memread,
               id_memwrite, id_alu_op, ex_stall, flush, wb_regwrite, wb_rd, wb_data,
        output load_use_stall, ex_valid, ex_pc, ID_EX_RegisterRs1, ID_EX_RegisterRs2,
               ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_regwrite, ex_memread,
               ex_memwrite, ex_alu_op, bubble_cnt
    );
endinterface

// File: rtl/ysyx_22040759_id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, writeback
// bypass on load, writeback capture while held, and a bubble counter.
module ysyx_22040759_id_ex_reg #(
    parameter int XLEN    = 64,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    ysyx_22040759_id_ex_reg_if.slave      bus
);
    // Per-edge update mode, in priority order.
    localparam logic [1:0] MODE_HOLD  = 2'd0;
    localparam logic [1:0] MODE_FLUSH = 2'd1;
    localparam logic [1:0] MODE_LUSE  = 2'd2;
    localparam logic [1:0] MODE_LOAD  = 2'd3;

    localparam logic [RA_W-1:0]  RA_ZERO  = {RA_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // A writeback targets register rs; x0 is never written.
    function automatic logic wbHits(input logic we, input logic [RA_W-1:0] wrd,
                                    input logic [RA_W-1:0] rs);
        return we & (wrd != RA_ZERO) & (wrd == rs);
    endfunction

    logic               exValid_r;
    logic [XLEN-1:0]    exPc_r;
    logic [RA_W-1:0]    exRs1_r;
    logic [RA_W-1:0]    exRs2_r;
    logic [RA_W-1:0]    exRd_r;
    logic [XLEN-1:0]    exRs1Data_r;
    logic [XLEN-1:0]    exRs2Data_r;
    logic [XLEN-1:0]    exImm_r;
    logic               exRegwrite_r;
    logic               exMemread_r;
    logic               exMemwrite_r;
    logic [ALUOP_W-1:0] exAluOp_r;
    logic [CNT_W-1:0]   bubbleCnt_r;

    logic               loadUseStall_s;
    logic [XLEN-1:0]    byp1_s;
    logic [XLEN-1:0]    byp2_s;
    logic               holdCap1_s;
    logic               holdCap2_s;
    logic [1:0]         mode_s;

    // Load-use detection: a load in EX whose rd is read by the valid ID instruction.
    always_comb begin
        loadUseStall_s = exValid_r & exMemread_r & (exRd_r != RA_ZERO) & bus.id_valid & ~bus.flush &
                         ((bus.id_rs1_ren & (exRd_r == bus.id_rs1)) |
                          (bus.id_rs2_ren & (exRd_r == bus.id_rs2)));
    end

    // Operand bypass from writeback so a same-cycle register write is not missed.
    always_comb begin
        byp1_s     = bus.id_rs1_data;
        byp2_s     = bus.id_rs2_data;
        holdCap1_s = exValid_r & wbHits(bus.wb_regwrite, bus.wb_rd, exRs1_r);
        holdCap2_s = exValid_r & wbHits(bus.wb_regwrite, bus.wb_rd, exRs2_r);
        if (wbHits(bus.wb_regwrite, bus.wb_rd, bus.id_rs1)) begin
            byp1_s = bus.wb_data;
        end else begin
            byp1_s = bus.id_rs1_data;
        end
        if (wbHits(bus.wb_regwrite, bus.wb_rd, bus.id_rs2)) begin
            byp2_s = bus.wb_data;
        end else begin
            byp2_s = bus.id_rs2_data;
        end
    end

    // Update mode select: hold beats flush beats load-use bubble beats load.
    always_comb begin
        mode_s = MODE_LOAD;
        if (bus.ex_stall) begin
            mode_s = MODE_HOLD;
        end else if (bus.flush) begin
            mode_s = MODE_FLUSH;
        end else if (loadUseStall_s) begin
            mode_s = MODE_LUSE;
        end else begin
            mode_s = MODE_LOAD;
        end
    end

    // Control and register-number fields; bubbles and invalid loads clear them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exValid_r    <= 1'b0;
            exRs1_r      <= RA_ZERO;
            exRs2_r      <= RA_ZERO;
            exRd_r       <= RA_ZERO;
            exRegwrite_r <= 1'b0;
            exMemread_r  <= 1'b0;
            exMemwrite_r <= 1'b0;
            exAluOp_r    <= {ALUOP_W{1'b0}};
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    exValid_r <= exValid_r;
                end
                MODE_FLUSH, MODE_LUSE: begin
                    exValid_r    <= 1'b0;
                    exRs1_r      <= RA_ZERO;
                    exRs2_r      <= RA_ZERO;
                    exRd_r       <= RA_ZERO;
                    exRegwrite_r <= 1'b0;
                    exMemread_r  <= 1'b0;
                    exMemwrite_r <= 1'b0;
                    exAluOp_r    <= {ALUOP_W{1'b0}};
                end
                MODE_LOAD: begin
                    exValid_r    <= bus.id_valid;
                    exRs1_r      <= bus.id_valid ? bus.id_rs1 : RA_ZERO;
                    exRs2_r      <= bus.id_valid ? bus.id_rs2 : RA_ZERO;
                    exRd_r       <= bus.id_valid ? bus.id_rd : RA_ZERO;
                    exRegwrite_r <= bus.id_valid & bus.id_regwrite;
                    exMemread_r  <= bus.id_valid & bus.id_memread;
                    exMemwrite_r <= bus.id_valid & bus.id_memwrite;
                    exAluOp_r    <= bus.id_valid ? bus.id_alu_op : {ALUOP_W{1'b0}};
                end
                default: begin
                    exValid_r <= 1'b0;
                end
            endcase
        end
    end

    // Data fields; while held, a writeback to a held source refreshes its operand.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exPc_r      <= {XLEN{1'b0}};
            exRs1Data_r <= {XLEN{1'b0}};
            exRs2Data_r <= {XLEN{1'b0}};
            exImm_r     <= {XLEN{1'b0}};
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    if (holdCap1_s) begin
                        exRs1Data_r <= bus.wb_data;
                    end
                    if (holdCap2_s) begin
                        exRs2Data_r <= bus.wb_data;
                    end
                end
                MODE_FLUSH, MODE_LUSE: begin
                    exPc_r <= exPc_r;
                end
                MODE_LOAD: begin
                    exPc_r      <= bus.id_pc;
                    exRs1Data_r <= byp1_s;
                    exRs2Data_r <= byp2_s;
                    exImm_r     <= bus.id_imm;
                end
                default: begin
                    exPc_r <= exPc_r;
                end
            endcase
        end
    end

    // Saturating count of load-use bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bubbleCnt_r <= {CNT_W{1'b0}};
        end else if ((mode_s == MODE_LUSE) && (bubbleCnt_r != CNT_MAX)) begin
            bubbleCnt_r <= bubbleCnt_r + CNT_ONE;
        end
    end

    assign bus.load_use_stall    = loadUseStall_s;
    assign bus.ex_valid          = exValid_r;
    assign bus.ex_pc             = exPc_r;
    assign bus.ID_EX_RegisterRs1 = exRs1_r;
    assign bus.ID_EX_RegisterRs2 = exRs2_r;
    assign bus.ex_rd             = exRd_r;
    assign bus.ex_rs1_data       = exRs1Data_r;
    assign bus.ex_rs2_data       = exRs2Data_r;
    assign bus.ex_imm            = exImm_r;
    assign bus.ex_regwrite       = exRegwrite_r;
    assign bus.ex_memread        = exMemread_r;
    assign bus.ex_memwrite       = exMemwrite_r;
    assign bus.ex_alu_op         = exAluOp_r;
    assign bus.bubble_cnt        = bubbleCnt_r;
endmodule

// File: tb/tb_ysyx_22040759_id_ex_reg.sv
// Directed bench for the ID/EX register: vector table plus hold,
// saturation and asynchronous-reset sequences.
module tb_ysyx_22040759_id_ex_reg;
    localparam int XLEN    = 64;
    localparam int RA_W    = 5;
    localparam int ALUOP_W = 5;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic        idValid;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ren1;
        logic        ren2;
        logic [4:0]  rd;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [4:0]  alu;
        logic        stall;
        logic        flush;
        logic        wbWe;
        logic [4:0]  wbRd;
        logic [63:0] wbData;
        logic        expLus;
        logic        expValid;
        logic [4:0]  expRs1;
        logic [4:0]  expRs2;
        logic [4:0]  expRd;
        logic        expRw;
        logic        expMr;
        logic        expMw;
        logic [4:0]  expAlu;
        logic        chkData;
        logic [63:0] expD1;
        logic [63:0] expD2;
        logic [2:0]  expCnt;
    } vec_t;

    logic clock;
    logic reset_n;
    int   nCmp;
    int   nBad;

    ysyx_22040759_id_ex_reg_if #(.XLEN(XLEN), .RA_W(RA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    ysyx_22040759_id_ex_reg #(.XLEN(XLEN), .RA_W(RA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid    = v.idValid;
        bus.id_pc       = v.pc;
        bus.id_rs1      = v.rs1;
        bus.id_rs2      = v.rs2;
        bus.id_rs1_ren  = v.ren1;
        bus.id_rs2_ren  = v.ren2;
        bus.id_rd       = v.rd;
        bus.id_rs1_data = v.d1;
        bus.id_rs2_data = v.d2;
        bus.id_imm      = v.imm;
        bus.id_regwrite = v.rw;
        bus.id_memread  = v.mr;
        bus.id_memwrite = v.mw;
        bus.id_alu_op   = v.alu;
        bus.ex_stall    = v.stall;
        bus.flush       = v.flush;
        bus.wb_regwrite = v.wbWe;
        bus.wb_rd       = v.wbRd;
        bus.wb_data     = v.wbData;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyVec(input vec_t v, input string tag);
        drive(v);
        #1;
        chk({tag, ".lus"}, bus.load_use_stall, v.expLus);
        step();
        chk({tag, ".valid"}, bus.ex_valid, v.expValid);
        chk({tag, ".rs1"}, bus.ID_EX_RegisterRs1, v.expRs1);
        chk({tag, ".rs2"}, bus.ID_EX_RegisterRs2, v.expRs2);
        chk({tag, ".rd"}, bus.ex_rd, v.expRd);
        chk({tag, ".regwrite"}, bus.ex_regwrite, v.expRw);
        chk({tag, ".memread"}, bus.ex_memread, v.expMr);
        chk({tag, ".memwrite"}, bus.ex_memwrite, v.expMw);
        chk({tag, ".aluop"}, bus.ex_alu_op, v.expAlu);
        chk({tag, ".bubcnt"}, bus.bubble_cnt, v.expCnt);
        if (v.chkData) begin
            chk({tag, ".d1"}, bus.ex_rs1_data, v.expD1);
            chk({tag, ".d2"}, bus.ex_rs2_data, v.expD2);
            chk({tag, ".pc"}, bus.ex_pc, v.pc);
            chk({tag, ".imm"}, bus.ex_imm, v.imm);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, ".valid"}, bus.ex_valid, 64'd0);
        chk({tag, ".pc"}, bus.ex_pc, 64'd0);
        chk({tag, ".rs1"}, bus.ID_EX_RegisterRs1, 64'd0);
        chk({tag, ".rs2"}, bus.ID_EX_RegisterRs2, 64'd0);
        chk({tag, ".rd"}, bus.ex_rd, 64'd0);
        chk({tag, ".d1"}, bus.ex_rs1_data, 64'd0);
        chk({tag, ".d2"}, bus.ex_rs2_data, 64'd0);
        chk({tag, ".imm"}, bus.ex_imm, 64'd0);
        chk({tag, ".regwrite"}, bus.ex_regwrite, 64'd0);
        chk({tag, ".memread"}, bus.ex_memread, 64'd0);
        chk({tag, ".memwrite"}, bus.ex_memwrite, 64'd0);
        chk({tag, ".aluop"}, bus.ex_alu_op, 64'd0);
        chk({tag, ".bubcnt"}, bus.bubble_cnt, 64'd0);
    endtask

    task automatic chkHeld(input string tag, input logic [63:0] expD2, input logic [2:0] expCnt);
        chk({tag, ".valid"}, bus.ex_valid, 64'd1);
        chk({tag, ".pc"}, bus.ex_pc, 64'h200);
        chk({tag, ".rs1"}, bus.ID_EX_RegisterRs1, 64'd6);
        chk({tag, ".rs2"}, bus.ID_EX_RegisterRs2, 64'd7);
        chk({tag, ".rd"}, bus.ex_rd, 64'd10);
        chk({tag, ".d1"}, bus.ex_rs1_data, 64'hA1);
        chk({tag, ".d2"}, bus.ex_rs2_data, expD2);
        chk({tag, ".imm"}, bus.ex_imm, 64'h10);
        chk({tag, ".regwrite"}, bus.ex_regwrite, 64'd1);
        chk({tag, ".memread"}, bus.ex_memread, 64'd1);
        chk({tag, ".memwrite"}, bus.ex_memwrite, 64'd0);
        chk({tag, ".aluop"}, bus.ex_alu_op, 64'd3);
        chk({tag, ".bubcnt"}, bus.bubble_cnt, {61'd0, expCnt});
    endtask

    vec_t vecs [14];
    vec_t v;
    vec_t lw;
    vec_t use5;
    logic [2:0] expCnt;

    initial begin
        nCmp    = 0;
        nBad    = 0;
        reset_n = 1'b0;
        drive('0);

        // 0: lw x5 enters an empty EX
        vecs[0]  = '{idValid:1'b1, pc:64'h100, rs1:5'd2, ren1:1'b1, rd:5'd5, d1:64'h1000, imm:64'h8,
                     rw:1'b1, mr:1'b1, alu:5'd1, expValid:1'b1, expRs1:5'd2, expRd:5'd5, expRw:1'b1,
                     expMr:1'b1, expAlu:5'd1, chkData:1'b1, expD1:64'h1000, expCnt:3'd0, default:'0};
        // 1: add reads x5 -> hazard, bubble
        vecs[1]  = '{idValid:1'b1, pc:64'h104, rs1:5'd5, rs2:5'd4, ren1:1'b1, ren2:1'b1, rd:5'd6,
                     d1:64'h55, d2:64'h44, rw:1'b1, alu:5'd2, expLus:1'b1, expCnt:3'd1, default:'0};
        // 2: add loads; load result bypassed from WB
        vecs[2]  = '{idValid:1'b1, pc:64'h104, rs1:5'd5, rs2:5'd4, ren1:1'b1, ren2:1'b1, rd:5'd6,
                     d1:64'h55, d2:64'h44, rw:1'b1, alu:5'd2, wbWe:1'b1, wbRd:5'd5, wbData:64'h777,
                     expValid:1'b1, expRs1:5'd5, expRs2:5'd4, expRd:5'd6, expRw:1'b1, expAlu:5'd2,
                     chkData:1'b1, expD1:64'h777, expD2:64'h44, expCnt:3'd1, default:'0};
        // 3: lw x5 again
        vecs[3]  = '{idValid:1'b1, pc:64'h108, rs1:5'd2, ren1:1'b1, rd:5'd5, d1:64'h1000, imm:64'h8,
                     rw:1'b1, mr:1'b1, alu:5'd1, expValid:1'b1, expRs1:5'd2, expRd:5'd5, expRw:1'b1,
                     expMr:1'b1, expAlu:5'd1, chkData:1'b1, expD1:64'h1000, expCnt:3'd1, default:'0};
        // 4: rs2=5 but not read -> no stall
        vecs[4]  = '{idValid:1'b1, pc:64'h10c, rs1:5'd1, rs2:5'd5, ren1:1'b1, rd:5'd7, d1:64'h11,
                     d2:64'h22, rw:1'b1, alu:5'd2, expValid:1'b1, expRs1:5'd1, expRs2:5'd5, expRd:5'd7,
                     expRw:1'b1, expAlu:5'd2, chkData:1'b1, expD1:64'h11, expD2:64'h22, expCnt:3'd1, default:'0};
        // 5: lw to x0
        vecs[5]  = '{idValid:1'b1, pc:64'h110, rs1:5'd2, ren1:1'b1, rd:5'd0, d1:64'h1000, rw:1'b1,
                     mr:1'b1, alu:5'd1, expValid:1'b1, expRs1:5'd2, expRw:1'b1, expMr:1'b1, expAlu:5'd1,
                     chkData:1'b1, expD1:64'h1000, expCnt:3'd1, default:'0};
        // 6: reads x0 behind lw x0 -> no stall; store-like control
        vecs[6]  = '{idValid:1'b1, pc:64'h114, ren1:1'b1, ren2:1'b1, rd:5'd8, d1:64'h33, d2:64'h34,
                     imm:64'h4, mw:1'b1, alu:5'd4, expValid:1'b1, expRd:5'd8, expMw:1'b1, expAlu:5'd4,
                     chkData:1'b1, expD1:64'h33, expD2:64'h34, expCnt:3'd1, default:'0};
        // 7: same-cycle WB bypass on rs1
        vecs[7]  = '{idValid:1'b1, pc:64'h118, rs1:5'd3, rs2:5'd9, ren1:1'b1, ren2:1'b1, rd:5'd10,
                     d1:64'h11, d2:64'h99, rw:1'b1, alu:5'd2, wbWe:1'b1, wbRd:5'd3, wbData:64'h22,
                     expValid:1'b1, expRs1:5'd3, expRs2:5'd9, expRd:5'd10, expRw:1'b1, expAlu:5'd2,
                     chkData:1'b1, expD1:64'h22, expD2:64'h99, expCnt:3'd1, default:'0};
        // 8: no bypass when WB not writing
        vecs[8]  = '{idValid:1'b1, pc:64'h11c, rs1:5'd3, rs2:5'd9, ren1:1'b1, ren2:1'b1, rd:5'd10,
                     d1:64'h11, d2:64'h99, rw:1'b1, alu:5'd2, wbWe:1'b0, wbRd:5'd3, wbData:64'h22,
                     expValid:1'b1, expRs1:5'd3, expRs2:5'd9, expRd:5'd10, expRw:1'b1, expAlu:5'd2,
                     chkData:1'b1, expD1:64'h11, expD2:64'h99, expCnt:3'd1, default:'0};
        // 9: WB to x0 never bypasses
        vecs[9]  = '{idValid:1'b1, pc:64'h120, rs2:5'd9, ren1:1'b1, rd:5'd11, d1:64'h5, d2:64'h99,
                     rw:1'b1, alu:5'd2, wbWe:1'b1, wbRd:5'd0, wbData:64'hAB, expValid:1'b1, expRs2:5'd9,
                     expRd:5'd11, expRw:1'b1, expAlu:5'd2, chkData:1'b1, expD1:64'h5, expD2:64'h99,
                     expCnt:3'd1, default:'0};
        // 10: invalid ID: control and register numbers load as zero
        vecs[10] = '{idValid:1'b0, pc:64'h124, rs1:5'd3, rs2:5'd4, ren1:1'b1, rd:5'd9, d1:64'h66,
                     d2:64'h67, imm:64'h9, rw:1'b1, mr:1'b1, mw:1'b1, chkData:1'b1, expD1:64'h66,
                     expD2:64'h67, expCnt:3'd1, default:'0};
        // 11: lw x5
        vecs[11] = '{idValid:1'b1, pc:64'h128, rs1:5'd2, ren1:1'b1, rd:5'd5, d1:64'h1000, imm:64'h8,
                     rw:1'b1, mr:1'b1, alu:5'd1, expValid:1'b1, expRs1:5'd2, expRd:5'd5, expRw:1'b1,
                     expMr:1'b1, expAlu:5'd1, chkData:1'b1, expD1:64'h1000, expCnt:3'd1, default:'0};
        // 12: flush gates the hazard; flush bubble, no count
        vecs[12] = '{idValid:1'b1, pc:64'h12c, rs1:5'd5, ren1:1'b1, rd:5'd6, rw:1'b1, alu:5'd2,
                     flush:1'b1, expCnt:3'd1, default:'0};
        // 13: instruction that will be held
        vecs[13] = '{idValid:1'b1, pc:64'h200, rs1:5'd6, rs2:5'd7, ren1:1'b1, ren2:1'b1, rd:5'd10,
                     d1:64'hA1, d2:64'hB2, imm:64'h10, rw:1'b1, mr:1'b1, alu:5'd3, expValid:1'b1,
                     expRs1:5'd6, expRs2:5'd7, expRd:5'd10, expRw:1'b1, expMr:1'b1, expAlu:5'd3,
                     chkData:1'b1, expD1:64'hA1, expD2:64'hB2, expCnt:3'd1, default:'0};

        #12;
        chkAllZero("reset");
        #8;
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            applyVec(vecs[i], $sformatf("v%0d", i));
        end

        // Hold for 3 cycles; ID reads x10 (held load's rd) so the stall output is high.
        v = '{idValid:1'b1, pc:64'h204, rs1:5'd10, ren1:1'b1, rd:5'd11, d1:64'h1, d2:64'h2,
              rw:1'b1, alu:5'd2, stall:1'b1, flush:1'b1, default:'0};
        drive(v);
        #1;
        chk("hold1.lus", bus.load_use_stall, 64'd0);
        step();
        chkHeld("hold1", 64'hB2, 3'd1);
        v.flush  = 1'b0;
        v.wbWe   = 1'b1;
        v.wbRd   = 5'd7;
        v.wbData = 64'hDEAD;
        drive(v);
        #1;
        chk("hold2.lus", bus.load_use_stall, 64'd1);
        step();
        chkHeld("hold2", 64'hDEAD, 3'd1);
        v.wbWe = 1'b0;
        drive(v);
        #1;
        chk("hold3.lus", bus.load_use_stall, 64'd1);
        step();
        chkHeld("hold3", 64'hDEAD, 3'd1);
        v.stall = 1'b0;
        drive(v);
        #1;
        chk("release.lus", bus.load_use_stall, 64'd1);
        step();
        chk("release.valid", bus.ex_valid, 64'd0);
        chk("release.memread", bus.ex_memread, 64'd0);
        chk("release.bubcnt", bus.bubble_cnt, 64'd2);

        // Repeated hazards drive the 3-bit counter to saturation.
        lw   = '{idValid:1'b1, pc:64'h300, rs1:5'd2, ren1:1'b1, rd:5'd5, d1:64'h1000, rw:1'b1,
                 mr:1'b1, alu:5'd1, default:'0};
        use5 = '{idValid:1'b1, pc:64'h304, rs1:5'd1, rs2:5'd5, ren2:1'b1, rd:5'd6, rw:1'b1,
                 alu:5'd2, default:'0};
        expCnt = 3'd2;
        for (int i = 0; i < 6; i++) begin
            drive(lw);
            step();
            drive(use5);
            #1;
            chk($sformatf("sat%0d.lus", i), bus.load_use_stall, 64'd1);
            step();
            expCnt = (expCnt == 3'd7) ? 3'd7 : expCnt + 3'd1;
            chk($sformatf("sat%0d.bubcnt", i), bus.bubble_cnt, {61'd0, expCnt});
        end

        // Asynchronous reset during a hold.
        v = '{idValid:1'b1, pc:64'h400, rs1:5'd12, rs2:5'd13, ren1:1'b1, ren2:1'b1, rd:5'd14,
              d1:64'hC1, d2:64'hC2, imm:64'h20, rw:1'b1, mw:1'b1, alu:5'd6, default:'0};
        drive(v);
        step();
        chk("pre_rst.valid", bus.ex_valid, 64'd1);
        v.stall = 1'b1;
        drive(v);
        step();
        chk("pre_rst.held_pc", bus.ex_pc, 64'h400);
        #2;
        reset_n = 1'b0;
        #1;
        chkAllZero("arst");
        #2;
        reset_n = 1'b1;
        drive('0);
        step();
        chk("post_rst.valid", bus.ex_valid, 64'd0);
        chk("post_rst.bubcnt", bus.bubble_cnt, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/ysyx_22040759_id_ex_reg.md
Name: ysyx_22040759_id_ex_reg

Overview:
- ID/EX pipeline register with built-in load-use hazard detection for the 5-stage core.
- Captures decoded operands and control from ID and presents them to EX. It is the source of the rs1/rs2 register numbers used by the downstream EX forwarding logic.
- Inserts a bubble on load-use hazards and on branch flush, and holds its contents under downstream stall.
- Captures writeback data so held or just-read operands never go stale.

Parameters:
- XLEN, 64, operand, immediate and PC data width.
- RA_W, 5, register address width.
- ALUOP_W, 5, ALU operation code width.
- CNT_W, 32, width of the bubble performance counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  XLEN  ID instruction PC.
- id_rs1, id_rs2  in  RA_W each  source register numbers.
- id_rs1_ren, id_rs2_ren  in  1 each  instruction actually reads rs1 / rs2.
- id_rd  in  RA_W  destination register.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  decoded immediate.
- id_regwrite, id_memread, id_memwrite  in  1 each  control bits.
- id_alu_op  in  ALUOP_W  ALU operation.
- ex_stall  in  1  EX/MEM cannot accept; hold this register.
- flush  in  1  branch/jump redirect resolved in EX; kill the instruction leaving ID.
- wb_regwrite  in  1  MEM/WB register write enable.
- wb_rd  in  RA_W  MEM/WB destination register.
- wb_data  in  XLEN  MEM/WB write data.
- load_use_stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX instruction valid.
- ex_pc  out  XLEN  registered PC.
- ID_EX_RegisterRs1, ID_EX_RegisterRs2  out  RA_W each  registered source numbers.
- ex_rd  out  RA_W  registered destination.
- ex_rs1_data, ex_rs2_data  out  XLEN each  registered operands.
- ex_imm  out  XLEN  registered immediate.
- ex_regwrite, ex_memread, ex_memwrite  out  1 each  registered control bits.
- ex_alu_op  out  ALUOP_W  registered ALU op.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:

Reset:
- reset_n low forces every registered output to 0 immediately (asynchronous), including bubble_cnt.
- Release is synchronous to clock.

Hazard (combinational):
- load_use_stall = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ~flush & ((id_rs1_ren & ex_rd == id_rs1) | (id_rs2_ren & ex_rd == id_rs2)).
- The output is independent of ex_stall.

Bypassed operands (combinational):
- byp1 = wb_data if wb_regwrite & wb_rd != 0 & wb_rd == id_rs1; otherwise id_rs1_data.
- byp2 is the same rule applied to id_rs2.

Per rising edge, strict priority:
1. ex_stall=1 (HOLD): all fields keep their value, with one exception. If ex_valid & wb_regwrite & wb_rd != 0 & wb_rd == ID_EX_RegisterRs1, ex_rs1_data <= wb_data; the same applies for rs2. flush and load_use_stall have no effect on this register in this cycle.
2. flush=1 (BUBBLE):
   - ex_valid, ex_regwrite, ex_memread, ex_memwrite <= 0.
   - ex_alu_op, ID_EX_RegisterRs1/Rs2 and ex_rd <= 0.
   - Data fields may keep their old values (don't-care).
3. load_use_stall=1 (BUBBLE): same as the flush bubble. In addition, bubble_cnt <= bubble_cnt + 1, saturating at all-ones.
4. Otherwise (LOAD):
   - All fields <= the ID inputs, with ex_rs1_data <= byp1 and ex_rs2_data <= byp2.
   - ex_valid <= id_valid.
   - If id_valid=0, the control bits and register numbers load as 0.

Timing and boundary rules:
- Latency is 1 cycle ID to EX.
- A load-use hazard costs exactly one bubble: the next cycle, ex_memread of the bubble is 0, so the stall drops.
- Register x0 never triggers a hazard, bypass or capture.
- Simultaneous flush and load_use cannot both be active, since flush gates the stall term.
- bubble_cnt never wraps.
- Reset asserted mid-hold discards the held instruction.

Test Plan:
1. Load-use: EX = lw x5 (ex_memread=1, ex_rd=5); ID = add reading rs1=5 with ren=1 -> load_use_stall=1 that cycle; next edge ex_valid=0 and bubble_cnt=1; following cycle load_use_stall=0 and add loads with ID_EX_RegisterRs1=5.
2. Non-read and x0 cases: the same lw with the ID instruction having id_rs2=5 but id_rs2_ren=0 -> no stall. lw to x0 with rs1=0 -> no stall.
3. Hold with capture: ex_stall=1 for 3 cycles, held ID_EX_RegisterRs2=7; wb_regwrite=1, wb_rd=7, wb_data=0xDEAD in cycle 2 -> ex_rs2_data=0xDEAD after that edge; all other fields unchanged throughout.
4. Flush vs stall: flush=1 with ex_stall=0 -> bubble, ex_valid=0, ex_regwrite=0. flush=1 with ex_stall=1 -> contents unchanged.
5. Same-cycle WB bypass on load: id_rs1=3, id_rs1_data=0x11, wb_rd=3, wb_data=0x22, wb_regwrite=1 -> ex_rs1_data=0x22. With wb_regwrite=0 -> ex_rs1_data=0x11.
6. Async reset: drop reset_n mid-cycle while fields are nonzero -> all outputs 0 before the next edge. Also preload bubble_cnt=all-ones, force a hazard -> bubble_cnt stays all-ones.
